reduce_stream: RTL

REDUCE_STREAM -- requirements
Module: reduce_stream

---
 rtl/reduce_stream.sv | 137 +++++++++++++
 1 files changed

// File: rtl/reduce_stream.sv
// Packet reducer: folds each beat's bitwise reduction into a single-bit accumulator
// and holds a registered result record (result, op, beat count, error) until it is consumed.
module reduce_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [2:0]       out_op,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_err
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is low only while a result is held; out_valid is high only then.
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [CNT_W-1:0] BEATS_MAX = '1;
    localparam logic [CNT_W-1:0] BEATS_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             acc_q, acc_d;
    logic             result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             err_q, err_d;

    logic             accept;
    logic             first;
    logic             illegal;
    logic [2:0]       op_sel;
    logic             red;
    logic             acc_new;

    always_comb begin
        in_ready  = (state_q != DONE);
        out_valid = (state_q == DONE);
        accept    = in_valid && in_ready;
        first     = (state_q == IDLE);
        illegal   = in_op[2] && in_op[1];

        // The op is latched from the first beat; illegal codes fall back to AND.
        if (first) begin
            op_sel = illegal ? 3'd0 : in_op;
        end else begin
            op_sel = op_q;
        end

        case (op_sel[2:1])
            2'b01:   red = |in_data;
            2'b10:   red = ^in_data;
            default: red = &in_data;
        endcase

        if (first) begin
            acc_new = red;
        end else begin
            case (op_sel[2:1])
                2'b01:   acc_new = acc_q | red;
                2'b10:   acc_new = acc_q ^ red;
                default: acc_new = acc_q & red;
            endcase
        end

        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        op_d     = op_q;
        beats_d  = beats_q;
        err_d    = err_q;

        if (accept) begin
            acc_d    = acc_new;
            op_d     = op_sel;
            result_d = op_sel[0] ? ~acc_new : acc_new;
            if (first) begin
                beats_d = BEATS_ONE;
                err_d   = illegal;
            end else if (beats_q == BEATS_MAX) begin
                err_d = 1'b1;
            end else begin
                beats_d = beats_q + BEATS_ONE;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && in_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= 1'b0;
            result_q <= 1'b0;
            op_q     <= 3'd0;
            beats_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            op_q     <= op_d;
            beats_q  <= beats_d;
            err_q    <= err_d;
        end
    end

    assign out_result = result_q;
    assign out_op     = op_q;
    assign out_beats  = beats_q;
    assign out_err    = err_q;

endmodule
